// File: rtl/icache_mshr.sv
// icache_mshr: miss-status holding registers between the instruction cache
// and the memory interface. Each slot tracks one outstanding block miss
// through FREE -> PENDING (awaiting a memory tag) -> WAIT (awaiting data) -> FREE.
// Up to two misses are captured per cycle, duplicates merge into existing
// slots, one load is issued per cycle, and returning blocks are forwarded to
// the icache write port one cycle after memory delivers them.
module icache_mshr #(
  parameter int MSHR_ENTRIES = 4,
  parameter int TAG_W        = 4,
  parameter int BLK_W        = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           miss_valid,
  input  logic [1:0][31:0]     miss_addr,
  output logic [1:0]           miss_accepted,
  output logic                 mshr_full,
  output logic                 mem_req_valid,
  output logic [31:0]          mem_req_addr,
  output logic [1:0]           mem_req_command,
  input  logic [TAG_W-1:0]     Imem2proc_transaction_tag,
  input  logic [BLK_W-1:0]     Imem2proc_data,
  input  logic [TAG_W-1:0]     Imem2proc_data_tag,
  output logic                 fill_valid,
  output logic [31:0]          fill_addr,
  output logic [BLK_W-1:0]     fill_data
);

  localparam int IDX_W = $clog2(MSHR_ENTRIES);
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_WAIT    = 2'd2
  } slot_state_e;

  slot_state_e        state_r     [MSHR_ENTRIES];
  slot_state_e        state_nxt_s [MSHR_ENTRIES];
  logic [28:0]        blk_r       [MSHR_ENTRIES];
  logic [28:0]        blk_nxt_s   [MSHR_ENTRIES];
  logic [TAG_W-1:0]   mtag_r      [MSHR_ENTRIES];
  logic [TAG_W-1:0]   mtag_nxt_s  [MSHR_ENTRIES];

  logic               fill_valid_r, fill_valid_nxt_s;
  logic [31:0]        fill_addr_r, fill_addr_nxt_s;
  logic [BLK_W-1:0]   fill_data_r, fill_data_nxt_s;

  logic [28:0]        blk0_s, blk1_s;
  logic               hit0_s, hit1_s, same_blk_s;
  logic               need0_s, need1_s;
  logic               free0_found_s, free1_found_s;
  logic [IDX_W-1:0]   free0_idx_s, free1_idx_s;
  logic               alloc0_s, alloc1_s;
  logic [IDX_W-1:0]   alloc1_idx_s;
  logic               acc0_s, acc1_s;
  logic               iss_found_s, iss_take_s;
  logic [IDX_W-1:0]   iss_idx_s;
  logic               fill_hit_s;
  logic [IDX_W-1:0]   fill_idx_s;
  logic               unused_addr_bits_s;

  // Byte offsets within a block do not participate in matching.
  assign unused_addr_bits_s = ^{miss_addr[0][2:0], miss_addr[1][2:0]};

  // Decode registered slot state against this cycle's misses, tags and data.
  always_comb begin
    blk0_s        = miss_addr[0][31:3];
    blk1_s        = miss_addr[1][31:3];
    hit0_s        = 1'b0;
    hit1_s        = 1'b0;
    free0_found_s = 1'b0;
    free1_found_s = 1'b0;
    free0_idx_s   = '0;
    free1_idx_s   = '0;
    iss_found_s   = 1'b0;
    iss_idx_s     = '0;
    fill_hit_s    = 1'b0;
    fill_idx_s    = '0;
    for (int i = 0; i < MSHR_ENTRIES; i++) begin
      // A slot in WAIT that is being filled this cycle still counts as a hit.
      if (state_r[i] != SLOT_FREE) begin
        if (blk_r[i] == blk0_s) begin
          hit0_s = 1'b1;
        end else begin
        end
        if (blk_r[i] == blk1_s) begin
          hit1_s = 1'b1;
        end else begin
        end
      end else if (!free0_found_s) begin
        free0_found_s = 1'b1;
        free0_idx_s   = IDX_W'(i);
      end else if (!free1_found_s) begin
        free1_found_s = 1'b1;
        free1_idx_s   = IDX_W'(i);
      end else begin
      end
      if (state_r[i] == SLOT_PENDING && !iss_found_s) begin
        iss_found_s = 1'b1;
        iss_idx_s   = IDX_W'(i);
      end else begin
      end
      if (state_r[i] == SLOT_WAIT && Imem2proc_data_tag != '0 &&
          mtag_r[i] == Imem2proc_data_tag) begin
        fill_hit_s = 1'b1;
        fill_idx_s = IDX_W'(i);
      end else begin
      end
    end
    same_blk_s   = miss_valid[0] && (blk0_s == blk1_s);
    need0_s      = miss_valid[0] && !hit0_s;
    need1_s      = miss_valid[1] && !hit1_s && !same_blk_s;
    alloc0_s     = need0_s && free0_found_s;
    // Miss 1 takes the next FREE slot after whatever miss 0 consumed.
    alloc1_s     = need1_s && (need0_s ? free1_found_s : free0_found_s);
    alloc1_idx_s = need0_s ? free1_idx_s : free0_idx_s;
    acc0_s       = miss_valid[0] && (hit0_s || alloc0_s);
    acc1_s       = same_blk_s ? (miss_valid[1] && acc0_s)
                              : (miss_valid[1] && (hit1_s || alloc1_s));
    iss_take_s   = iss_found_s && (Imem2proc_transaction_tag != '0);
  end

  // Next-state: issue, fill and allocation act on disjoint slot states.
  always_comb begin
    for (int i = 0; i < MSHR_ENTRIES; i++) begin
      state_nxt_s[i] = state_r[i];
      blk_nxt_s[i]   = blk_r[i];
      mtag_nxt_s[i]  = mtag_r[i];
    end
    if (iss_take_s) begin
      state_nxt_s[iss_idx_s] = SLOT_WAIT;
      mtag_nxt_s[iss_idx_s]  = Imem2proc_transaction_tag;
    end else begin
    end
    if (fill_hit_s) begin
      state_nxt_s[fill_idx_s] = SLOT_FREE;
    end else begin
    end
    if (alloc0_s) begin
      state_nxt_s[free0_idx_s] = SLOT_PENDING;
      blk_nxt_s[free0_idx_s]   = blk0_s;
    end else begin
    end
    if (alloc1_s) begin
      state_nxt_s[alloc1_idx_s] = SLOT_PENDING;
      blk_nxt_s[alloc1_idx_s]   = blk1_s;
    end else begin
    end
    fill_valid_nxt_s = fill_hit_s;
    if (fill_hit_s) begin
      fill_addr_nxt_s = {blk_r[fill_idx_s], 3'b000};
      fill_data_nxt_s = Imem2proc_data;
    end else begin
      fill_addr_nxt_s = fill_addr_r;
      fill_data_nxt_s = fill_data_r;
    end
  end

  // State register: synchronous reset drops every outstanding entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MSHR_ENTRIES; i++) begin
        state_r[i] <= SLOT_FREE;
        blk_r[i]   <= 29'd0;
        mtag_r[i]  <= '0;
      end
      fill_valid_r <= 1'b0;
      fill_addr_r  <= 32'd0;
      fill_data_r  <= '0;
    end else begin
      for (int i = 0; i < MSHR_ENTRIES; i++) begin
        state_r[i] <= state_nxt_s[i];
        blk_r[i]   <= blk_nxt_s[i];
        mtag_r[i]  <= mtag_nxt_s[i];
      end
      fill_valid_r <= fill_valid_nxt_s;
      fill_addr_r  <= fill_addr_nxt_s;
      fill_data_r  <= fill_data_nxt_s;
    end
  end

  // Outputs: request and full flag decode registered state only.
  always_comb begin
    miss_accepted = {acc1_s, acc0_s};
    mshr_full     = !free0_found_s;
    mem_req_valid = iss_found_s;
    if (iss_found_s) begin
      mem_req_addr    = {blk_r[iss_idx_s], 3'b000};
      mem_req_command = MEM_LOAD;
    end else begin
      mem_req_addr    = 32'd0;
      mem_req_command = MEM_NONE;
    end
    fill_valid = fill_valid_r;
    fill_addr  = fill_addr_r;
    fill_data  = fill_data_r;
  end

endmodule

// File: tb/tb_icache_mshr.sv
// Directed bench for icache_mshr: inputs change just after the rising edge,
// outputs are compared on the falling edge.
module tb_icache_mshr;

  logic             clock;
  logic             reset;
  logic [1:0]       miss_valid;
  logic [1:0][31:0] miss_addr;
  logic [1:0]       miss_accepted;
  logic             mshr_full;
  logic             mem_req_valid;
  logic [31:0]      mem_req_addr;
  logic [1:0]       mem_req_command;
  logic [3:0]       ttag;
  logic [63:0]      mdata;
  logic [3:0]       dtag;
  logic             fill_valid;
  logic [31:0]      fill_addr;
  logic [63:0]      fill_data;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] DATA1 = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DATA2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DATA3 = 64'hA5A5_5A5A_F00D_CAFE;
  localparam logic [63:0] DATA4 = 64'h9999_8888_7777_6666;
  localparam logic [63:0] DATA5 = 64'h0BAD_F00D_1234_5678;
  localparam logic [63:0] DATA6 = 64'hFFFF_0000_FFFF_0000;

  icache_mshr #(.MSHR_ENTRIES(4), .TAG_W(4), .BLK_W(64)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .miss_valid                (miss_valid),
    .miss_addr                 (miss_addr),
    .miss_accepted             (miss_accepted),
    .mshr_full                 (mshr_full),
    .mem_req_valid             (mem_req_valid),
    .mem_req_addr              (mem_req_addr),
    .mem_req_command           (mem_req_command),
    .Imem2proc_transaction_tag (ttag),
    .Imem2proc_data            (mdata),
    .Imem2proc_data_tag        (dtag),
    .fill_valid                (fill_valid),
    .fill_addr                 (fill_addr),
    .fill_data                 (fill_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] tt, input logic [3:0] dt, input logic [63:0] d);
    miss_valid   = v;
    miss_addr[0] = a0;
    miss_addr[1] = a1;
    ttag         = tt;
    dtag         = dt;
    mdata        = d;
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    nxt();
    nxt();
    reset = 1'b0;

    // Reset state and 10 idle cycles
    @(negedge clock);
    chk("rst_fill_valid", {63'd0, fill_valid}, 64'd0);
    chk("rst_fill_addr", {32'd0, fill_addr}, 64'd0);
    chk("rst_fill_data", fill_data, 64'd0);
    chk("rst_req_cmd", {62'd0, mem_req_command}, 64'd0);
    chk("rst_accepted", {62'd0, miss_accepted}, 64'd0);
    for (int k = 0; k < 10; k++) begin
      if (k != 0) @(negedge clock);
      chk("idle_req_valid", {63'd0, mem_req_valid}, 64'd0);
      chk("idle_fill_valid", {63'd0, fill_valid}, 64'd0);
      chk("idle_full", {63'd0, mshr_full}, 64'd0);
    end
    nxt();

    // Single miss to 0x104
    drive(2'b01, 32'h104, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("single_acc", {62'd0, miss_accepted}, 64'd1);
    chk("single_noreq_c0", {63'd0, mem_req_valid}, 64'd0);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd3, 4'd0, 64'h0);
    @(negedge clock);
    chk("single_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("single_req_addr", {32'd0, mem_req_addr}, 64'h100);
    chk("single_req_cmd", {62'd0, mem_req_command}, 64'd1);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("single_wait_noreq", {63'd0, mem_req_valid}, 64'd0);
      chk("single_wait_nofill", {63'd0, fill_valid}, 64'd0);
      nxt();
    end
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd3, DATA1);
    @(negedge clock);
    chk("single_fill_not_yet", {63'd0, fill_valid}, 64'd0);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("single_fill_valid", {63'd0, fill_valid}, 64'd1);
    chk("single_fill_addr", {32'd0, fill_addr}, 64'h100);
    chk("single_fill_data", fill_data, DATA1);
    nxt();
    @(negedge clock);
    chk("single_fill_drop", {63'd0, fill_valid}, 64'd0);
    nxt();

    // Dual miss to the same block
    drive(2'b11, 32'h200, 32'h204, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("dual_acc", {62'd0, miss_accepted}, 64'd3);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd5, 4'd0, 64'h0);
    @(negedge clock);
    chk("dual_req_valid", {63'd0, mem_req_valid}, 64'd1);
    chk("dual_req_addr", {32'd0, mem_req_addr}, 64'h200);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("dual_one_req", {63'd0, mem_req_valid}, 64'd0);
    nxt();

    // Merge into WAIT slot, including the cycle it is filled
    drive(2'b01, 32'h300, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("wait_first_acc", {62'd0, miss_accepted}, 64'd1);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd6, 4'd0, 64'h0);
    @(negedge clock);
    chk("wait_req_addr", {32'd0, mem_req_addr}, 64'h300);
    nxt();
    drive(2'b01, 32'h300, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("wait_merge_acc", {62'd0, miss_accepted}, 64'd1);
    chk("wait_merge_noreq", {63'd0, mem_req_valid}, 64'd0);
    nxt();
    drive(2'b01, 32'h304, 32'h0, 4'd0, 4'd6, DATA2);
    @(negedge clock);
    chk("wait_fillcyc_acc", {62'd0, miss_accepted}, 64'd1);
    chk("wait_fillcyc_noreq", {63'd0, mem_req_valid}, 64'd0);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd5, DATA3);
    @(negedge clock);
    chk("wait_fill_valid", {63'd0, fill_valid}, 64'd1);
    chk("wait_fill_addr", {32'd0, fill_addr}, 64'h300);
    chk("wait_fill_data", fill_data, DATA2);
    chk("wait_no_realloc", {63'd0, mem_req_valid}, 64'd0);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd9, DATA4);
    @(negedge clock);
    chk("fill200_addr", {32'd0, fill_addr}, 64'h200);
    chk("fill200_data", fill_data, DATA3);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("unmatched_tag_nofill", {63'd0, fill_valid}, 64'd0);
    chk("empty_not_full", {63'd0, mshr_full}, 64'd0);
    nxt();

    // Rejection: tag 0 three times, accepted on the 4th request
    drive(2'b01, 32'h400, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("rej_acc", {62'd0, miss_accepted}, 64'd1);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rej_retry_valid", {63'd0, mem_req_valid}, 64'd1);
      chk("rej_retry_addr", {32'd0, mem_req_addr}, 64'h400);
      nxt();
    end
    drive(2'b00, 32'h0, 32'h0, 4'd7, 4'd0, 64'h0);
    @(negedge clock);
    chk("rej_4th_addr", {32'd0, mem_req_addr}, 64'h400);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("rej_stored", {63'd0, mem_req_valid}, 64'd0);
    nxt();

    // Fill all four slots, then overflow
    drive(2'b11, 32'h600, 32'h700, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("full_two_alloc_acc", {62'd0, miss_accepted}, 64'd3);
    chk("full_not_yet", {63'd0, mshr_full}, 64'd0);
    nxt();
    drive(2'b01, 32'h800, 32'h0, 4'd8, 4'd0, 64'h0);
    @(negedge clock);
    chk("full_third_acc", {62'd0, miss_accepted}, 64'd1);
    chk("full_req600", {32'd0, mem_req_addr}, 64'h600);
    nxt();
    drive(2'b01, 32'h500, 32'h0, 4'd9, 4'd0, 64'h0);
    @(negedge clock);
    chk("full_flag", {63'd0, mshr_full}, 64'd1);
    chk("full_reject", {62'd0, miss_accepted}, 64'd0);
    chk("full_req700", {32'd0, mem_req_addr}, 64'h700);
    nxt();
    drive(2'b01, 32'h500, 32'h0, 4'd10, 4'd0, 64'h0);
    @(negedge clock);
    chk("full_reject2", {62'd0, miss_accepted}, 64'd0);
    chk("full_req800", {32'd0, mem_req_addr}, 64'h800);
    nxt();
    drive(2'b01, 32'h500, 32'h0, 4'd0, 4'd7, DATA5);
    @(negedge clock);
    chk("fillcyc_reject", {62'd0, miss_accepted}, 64'd0);
    chk("fillcyc_full", {63'd0, mshr_full}, 64'd1);
    chk("fillcyc_noreq", {63'd0, mem_req_valid}, 64'd0);
    nxt();
    drive(2'b11, 32'h500, 32'h900, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("reuse_acc", {62'd0, miss_accepted}, 64'd1);
    chk("reuse_not_full", {63'd0, mshr_full}, 64'd0);
    chk("reuse_fill_valid", {63'd0, fill_valid}, 64'd1);
    chk("reuse_fill_addr", {32'd0, fill_addr}, 64'h400);
    chk("reuse_fill_data", fill_data, DATA5);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("reuse_full_again", {63'd0, mshr_full}, 64'd1);
    chk("reuse_req500", {32'd0, mem_req_addr}, 64'h500);
    nxt();

    // Reset mid-flight; stale tags afterwards are ignored
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd8, DATA6);
    @(negedge clock);
    chk("midrst_full", {63'd0, mshr_full}, 64'd0);
    chk("midrst_noreq", {63'd0, mem_req_valid}, 64'd0);
    chk("midrst_nofill", {63'd0, fill_valid}, 64'd0);
    nxt();
    drive(2'b00, 32'h0, 32'h0, 4'd0, 4'd0, 64'h0);
    @(negedge clock);
    chk("stale_tag_nofill", {63'd0, fill_valid}, 64'd0);
    chk("stale_tag_addr", {32'd0, fill_addr}, 64'd0);
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
